// File: rtl/axis_pattern_master_pkg.sv
// Shared constants and types for the AXI-Stream pattern source.
package axis_pattern_master_pkg;

    // Register map of the write-only configuration port
    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_LEN  = 2'd1;
    localparam logic [1:0] ADDR_GAP  = 2'd2;
    localparam logic [1:0] ADDR_SEED = 2'd3;

    // CTRL bit positions
    localparam int CTRL_ENA_BIT  = 31;
    localparam int CTRL_CONT_BIT = 30;

    // Galois LFSR feedback taps (right-shifting form)
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_LFSR    = 2'd1,
        MODE_CONST   = 2'd2,
        MODE_RSVD    = 2'd3   // behaves like the counter
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/axis_pattern_master_if.sv
// AXI-Stream bus between the pattern source (master) and its sink (slave).
interface axis_pattern_master_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0]   axis_tdata;
    logic [DATA_WIDTH/8-1:0] axis_tkeep;
    logic                    axis_tlast;
    logic                    axis_tvalid;
    logic                    axis_tready;

    modport master (
        output axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
        input  axis_tready
    );

    modport slave (
        input  axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
        output axis_tready
    );
endinterface

// File: rtl/axis_pattern_gen.sv
// 32-bit payload generator: counter, Galois LFSR or constant word.
module axis_pattern_gen
    import axis_pattern_master_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,       // load from seed (takes priority)
    input  mode_e       load_mode_i,  // mode in force for the load
    input  logic [31:0] seed_i,
    input  logic        adv_i,        // step once (beat accepted)
    input  mode_e       mode_i,       // mode of the packet being sent
    output logic [31:0] value_o
);

    logic [31:0] value_q, value_d;

    // Next pattern word: load wins over advance; LFSR never loads the lock-up value 0
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            if (load_mode_i == MODE_LFSR && seed_i == 32'h0)
                value_d = 32'h1;
            else
                value_d = seed_i;
        end else if (adv_i) begin
            case (mode_i)
                MODE_LFSR:  value_d = lfsr_next(value_q);
                MODE_CONST: value_d = value_q;
                default:    value_d = value_q + 32'd1;
            endcase
        end
    end

    // Pattern register
    always_ff @(posedge clk_i) begin
        if (rst_i) value_q <= 32'h0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/axis_pattern_master.sv
// AXI-Stream test-pattern source with programmable packet length, gap and payload.
module axis_pattern_master
    import axis_pattern_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 26,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                 axis_aclk,
    input  logic                 axis_reset,
    input  logic [1:0]           cfg_waddr,
    input  logic [31:0]          cfg_wdata,
    input  logic                 cfg_wvalid,
    output logic                 cfg_wready,
    output logic                 status_busy,
    output logic [31:0]          status_pktCount,
    output logic [LEN_WIDTH:0]   status_beatCount,
    axis_pattern_master_if.master axis
);

    localparam logic [LEN_WIDTH:0]   BEAT_ONE = 1;
    localparam logic [GAP_WIDTH-1:0] GAP_ONE  = 1;

    // ---------------- configuration registers ----------------
    logic                 ena_q, ena_d, cont_q, cont_d;
    mode_e                mode_q, mode_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic [31:0]          seed_q, seed_d;

    // Register writes; the _d values are also what a starting packet sees,
    // so an enabling CTRL write starts sending on the very next cycle
    always_comb begin
        ena_d  = ena_q;
        cont_d = cont_q;
        mode_d = mode_q;
        len_d  = len_q;
        gap_d  = gap_q;
        seed_d = seed_q;
        if (cfg_wvalid) begin
            case (cfg_waddr)
                ADDR_CTRL: begin
                    ena_d  = cfg_wdata[CTRL_ENA_BIT];
                    cont_d = cfg_wdata[CTRL_CONT_BIT];
                    mode_d = mode_e'(cfg_wdata[1:0]);
                end
                ADDR_LEN:  len_d  = cfg_wdata[LEN_WIDTH-1:0];
                ADDR_GAP:  gap_d  = cfg_wdata[GAP_WIDTH-1:0];
                default:   seed_d = cfg_wdata;
            endcase
        end
    end

    // Configuration register state
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            ena_q  <= 1'b0;
            cont_q <= 1'b0;
            mode_q <= MODE_COUNTER;
            len_q  <= '0;
            gap_q  <= '0;
            seed_q <= 32'h0;
        end else begin
            ena_q  <= ena_d;
            cont_q <= cont_d;
            mode_q <= mode_d;
            len_q  <= len_d;
            gap_q  <= gap_d;
            seed_q <= seed_d;
        end
    end

    // ---------------- sequencer ----------------
    state_e               state_q, state_d;
    logic [LEN_WIDTH:0]   beat_q, beat_d;
    logic [31:0]          pkt_q, pkt_d;
    logic [GAP_WIDTH-1:0] gcnt_q, gcnt_d;
    logic [LEN_WIDTH-1:0] len_sh_q, len_sh_d;
    logic [GAP_WIDTH-1:0] gap_sh_q, gap_sh_d;
    mode_e                mode_sh_q, mode_sh_d;
    logic                 cont_sh_q, cont_sh_d;
    logic                 start_pkt, pat_load, pat_adv, last_beat;
    logic [31:0]          pat;

    assign last_beat = (beat_q == {1'b0, len_sh_q});

    // Next state, counters and packet-start shadowing
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        pkt_d     = pkt_q;
        gcnt_d    = gcnt_q;
        len_sh_d  = len_sh_q;
        gap_sh_d  = gap_sh_q;
        mode_sh_d = mode_sh_q;
        cont_sh_d = cont_sh_q;
        start_pkt = 1'b0;
        pat_load  = 1'b0;
        pat_adv   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ena_d) begin
                    state_d   = ST_SEND;
                    pat_load  = 1'b1;
                    beat_d    = '0;
                    pkt_d     = 32'h0;
                    start_pkt = 1'b1;
                end
            end
            ST_SEND: begin
                if (axis.axis_tready) begin
                    pat_adv = 1'b1;
                    beat_d  = beat_q + BEAT_ONE;
                    if (last_beat) begin
                        pkt_d = pkt_q + 32'd1;
                        if (cont_sh_q && ena_d) begin
                            if (gap_sh_q == '0) begin
                                beat_d    = '0;
                                start_pkt = 1'b1;
                            end else begin
                                state_d = ST_GAP;
                                gcnt_d  = gap_sh_q - GAP_ONE;
                            end
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (!ena_d) begin
                    state_d = ST_IDLE;
                end else if (gcnt_q == '0) begin
                    state_d   = ST_SEND;
                    beat_d    = '0;
                    start_pkt = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - GAP_ONE;
                end
            end
            default: begin  // ST_DONE
                if (!ena_d) state_d = ST_IDLE;
            end
        endcase
        if (start_pkt) begin
            len_sh_d  = len_d;
            gap_sh_d  = gap_d;
            mode_sh_d = mode_d;
            cont_sh_d = cont_d;
        end
    end

    // Sequencer state
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            pkt_q     <= 32'h0;
            gcnt_q    <= '0;
            len_sh_q  <= '0;
            gap_sh_q  <= '0;
            mode_sh_q <= MODE_COUNTER;
            cont_sh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            pkt_q     <= pkt_d;
            gcnt_q    <= gcnt_d;
            len_sh_q  <= len_sh_d;
            gap_sh_q  <= gap_sh_d;
            mode_sh_q <= mode_sh_d;
            cont_sh_q <= cont_sh_d;
        end
    end

    axis_pattern_gen u_gen (
        .clk_i       (axis_aclk),
        .rst_i       (axis_reset),
        .load_i      (pat_load),
        .load_mode_i (mode_d),
        .seed_i      (seed_d),
        .adv_i       (pat_adv),
        .mode_i      (mode_sh_q),
        .value_o     (pat)
    );

    // Outputs decode registered state only; tready never reaches tvalid
    assign axis.axis_tvalid = (state_q == ST_SEND);
    assign axis.axis_tlast  = axis.axis_tvalid && last_beat;
    assign axis.axis_tkeep  = {(DATA_WIDTH/8){axis.axis_tvalid}};
    assign axis.axis_tdata  = axis.axis_tvalid ? {(DATA_WIDTH/32){pat}} : '0;

    assign cfg_wready       = 1'b1;
    assign status_busy      = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign status_pktCount  = pkt_q;
    assign status_beatCount = beat_q;

endmodule

// File: tb/tb_axis_pattern_master.sv
// Directed bench for axis_pattern_master: table of single packets plus
// hand-written sequences for gaps, stalls, ena clearing, reset and 64-bit width.
module tb_axis_pattern_master;
    import axis_pattern_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_waddr;
    logic [31:0] cfg_wdata;
    logic        wvalid32, wvalid64;
    logic        wready32, wready64;
    logic        busy32, busy64;
    logic [31:0] pkt32, pkt64;
    logic [26:0] beat32, beat64;

    axis_pattern_master_if #(.DATA_WIDTH(32)) ax   ();
    axis_pattern_master_if #(.DATA_WIDTH(64)) ax64 ();

    axis_pattern_master #(.DATA_WIDTH(32)) dut (
        .axis_aclk(clk), .axis_reset(rst),
        .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata), .cfg_wvalid(wvalid32), .cfg_wready(wready32),
        .status_busy(busy32), .status_pktCount(pkt32), .status_beatCount(beat32),
        .axis(ax.master)
    );

    axis_pattern_master #(.DATA_WIDTH(64)) dut64 (
        .axis_aclk(clk), .axis_reset(rst),
        .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata), .cfg_wvalid(wvalid64), .cfg_wready(wready64),
        .status_busy(busy64), .status_pktCount(pkt64), .status_beatCount(beat64),
        .axis(ax64.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // All tasks start and end one time unit after a rising edge.
    task automatic cfg_write(input bit to64, input logic [1:0] a, input logic [31:0] d);
        cfg_waddr = a;
        cfg_wdata = d;
        if (to64) wvalid64 = 1'b1; else wvalid32 = 1'b1;
        @(posedge clk); #1;
        wvalid32 = 1'b0;
        wvalid64 = 1'b0;
    endtask

    logic [31:0] cap_d [16];
    logic        cap_l [16];
    int          cap_n, cap_first;

    // Capture nexp accepted beats; optionally randomise tready and check stalls hold.
    task automatic collect(input int nexp, input bit rnd);
        logic [31:0] hd;
        logic        hl;
        bit          st;
        int          cyc;
        st = 0; cyc = 0; cap_n = 0; cap_first = -1; hd = '0; hl = 1'b0;
        while (cap_n < nexp && cyc < 300) begin
            ax.axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            if (st) begin
                chk("hold_valid", 64'(ax.axis_tvalid), 64'd1);
                chk("hold_data", 64'(ax.axis_tdata), 64'(hd));
                chk("hold_last", 64'(ax.axis_tlast), 64'(hl));
            end
            if (ax.axis_tvalid) begin
                if (ax.axis_tready) begin
                    if (cap_first < 0) cap_first = cyc;
                    cap_d[cap_n] = ax.axis_tdata;
                    cap_l[cap_n] = ax.axis_tlast;
                    cap_n++;
                    st = 0;
                end else begin
                    st = 1;
                    hd = ax.axis_tdata;
                    hl = ax.axis_tlast;
                end
            end
            @(posedge clk); #1;
        end
        ax.axis_tready = 1'b1;
        if (cap_n < nexp) chk("collect_timeout", 64'(cap_n), 64'(nexp));
    endtask

    // Wait (bounded) until the 32-bit source is no longer busy.
    task automatic wait_idle();
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy32) break;
            @(posedge clk); #1;
        end
        if (k == 30) chk("idle_timeout", 64'(busy32), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic [1:0]       mode;
        logic [31:0]      seed;
        logic [3:0]       len;
        logic [3:0][31:0] exp;   // exp[b] = expected word of beat b
    } vec_t;

    function automatic vec_t mk(input logic [1:0] m, input logic [31:0] s, input logic [3:0] l,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.mode = m; v.seed = s; v.len = l;
        v.exp  = {e3, e2, e1, e0};
        return v;
    endfunction

    vec_t vt [6];

    task automatic run_vec(input vec_t v, input bit rnd, input string tag);
        cfg_write(0, ADDR_SEED, v.seed);
        cfg_write(0, ADDR_LEN, 32'(v.len));
        cfg_write(0, ADDR_CTRL, 32'h8000_0000 | 32'(v.mode));
        collect(int'(v.len) + 1, rnd);
        if (!rnd) chk({tag, "_latency"}, 64'(cap_first), 64'd1);
        for (int b = 0; b <= int'(v.len); b++) begin
            chk({tag, "_data"}, 64'(cap_d[b]), 64'(v.exp[b]));
            chk({tag, "_last"}, 64'(cap_l[b]), 64'(b == int'(v.len)));
        end
        @(negedge clk);
        chk({tag, "_done_valid"}, 64'(ax.axis_tvalid), 64'd0);
        chk({tag, "_done_pkt"}, 64'(pkt32), 64'd1);
        chk({tag, "_done_beat"}, 64'(beat32), 64'(v.len) + 64'd1);
        chk({tag, "_done_busy"}, 64'(busy32), 64'd0);
        @(posedge clk); #1;
        cfg_write(0, ADDR_CTRL, 32'h0);
    endtask

    initial begin
        logic [11:0] expv;
        int          k;

        vt[0] = mk(2'd0, 32'd10,        4'd3, 32'd10, 32'd11, 32'd12, 32'd13);
        vt[1] = mk(2'd1, 32'd1,         4'd1, 32'h1, 32'h8020_0003, 32'h0, 32'h0);
        vt[2] = mk(2'd1, 32'd0,         4'd1, 32'h1, 32'h8020_0003, 32'h0, 32'h0);
        vt[3] = mk(2'd2, 32'h1234_5678, 4'd2, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h0);
        vt[4] = mk(2'd3, 32'hFFFF_FFFE, 4'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1);
        vt[5] = mk(2'd1, 32'd1,         4'd3, 32'h1, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001);

        rst = 1'b1; wvalid32 = 1'b0; wvalid64 = 1'b0; cfg_waddr = '0; cfg_wdata = '0;
        ax.axis_tready = 1'b1; ax64.axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", 64'(ax.axis_tvalid), 64'd0);
        chk("rst_tlast",  64'(ax.axis_tlast), 64'd0);
        chk("rst_tkeep",  64'(ax.axis_tkeep), 64'd0);
        chk("rst_tdata",  64'(ax.axis_tdata), 64'd0);
        chk("rst_busy",   64'(busy32), 64'd0);
        chk("rst_pkt",    64'(pkt32), 64'd0);
        chk("rst_beat",   64'(beat32), 64'd0);
        chk("rst_wready", 64'(wready32), 64'd1);
        chk("rst_tkeep64", 64'(ax64.axis_tkeep), 64'd0);
        @(posedge clk); #1;

        // Single-packet table
        for (int i = 0; i < 6; i++) run_vec(vt[i], 1'b0, $sformatf("vec%0d", i));

        // Same LFSR packet under random back-pressure
        run_vec(vt[5], 1'b1, "stall");

        // Continuous, LEN=1, GAP=2: two beats, two idle cycles, repeat
        cfg_write(0, ADDR_SEED, 32'd100);
        cfg_write(0, ADDR_LEN, 32'd1);
        cfg_write(0, ADDR_GAP, 32'd2);
        cfg_write(0, ADDR_CTRL, 32'hC000_0000);
        expv = 12'b1100_1100_1100;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("gap_valid", 64'(ax.axis_tvalid), 64'(expv[11-i]));
            if (ax.axis_tvalid) begin
                chk("gap_data", 64'(ax.axis_tdata), 64'(100 + k));
                chk("gap_last", 64'(ax.axis_tlast), 64'(k % 2 == 1));
                k++;
            end
            @(posedge clk); #1;
        end
        cfg_write(0, ADDR_CTRL, 32'h0);
        wait_idle();

        // Continuous, GAP=0: back-to-back, tlast every second beat
        cfg_write(0, ADDR_GAP, 32'd0);
        cfg_write(0, ADDR_CTRL, 32'hC000_0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_valid", 64'(ax.axis_tvalid), 64'd1);
            chk("b2b_data", 64'(ax.axis_tdata), 64'(100 + i));
            chk("b2b_last", 64'(ax.axis_tlast), 64'(i % 2 == 1));
            if (i == 4) chk("b2b_pkt", 64'(pkt32), 64'd2);
            @(posedge clk); #1;
        end
        cfg_write(0, ADDR_CTRL, 32'h0);
        wait_idle();

        // ena cleared during beat 1 of an 8-beat packet: packet still completes
        cfg_write(0, ADDR_SEED, 32'd0);
        cfg_write(0, ADDR_LEN, 32'd7);
        cfg_write(0, ADDR_CTRL, 32'h8000_0000);
        for (int i = 0; i < 10; i++) begin
            cfg_waddr = ADDR_CTRL;
            cfg_wdata = 32'h0;
            wvalid32  = (i == 1);
            @(negedge clk);
            chk("ena_valid", 64'(ax.axis_tvalid), 64'(i < 8));
            if (i < 8) begin
                chk("ena_data", 64'(ax.axis_tdata), 64'(i));
                chk("ena_last", 64'(ax.axis_tlast), 64'(i == 7));
            end
            if (i == 8) chk("ena_pkt", 64'(pkt32), 64'd1);
            @(posedge clk); #1;
        end
        wvalid32 = 1'b0;
        // Back in IDLE: re-enable restarts from the seed with pktCount cleared
        cfg_write(0, ADDR_CTRL, 32'h8000_0000);
        @(negedge clk);
        chk("restart_valid", 64'(ax.axis_tvalid), 64'd1);
        chk("restart_data", 64'(ax.axis_tdata), 64'd0);
        chk("restart_pkt", 64'(pkt32), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset in the middle of that packet
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_tvalid", 64'(ax.axis_tvalid), 64'd0);
        chk("mrst_tlast",  64'(ax.axis_tlast), 64'd0);
        chk("mrst_tkeep",  64'(ax.axis_tkeep), 64'd0);
        chk("mrst_tdata",  64'(ax.axis_tdata), 64'd0);
        chk("mrst_busy",   64'(busy32), 64'd0);
        chk("mrst_beat",   64'(beat32), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mrst_stays_idle", 64'(ax.axis_tvalid), 64'd0);
        @(posedge clk); #1;

        // 64-bit instance, constant mode
        cfg_write(1, ADDR_SEED, 32'hDEAD_BEEF);
        cfg_write(1, ADDR_LEN, 32'd1);
        cfg_write(1, ADDR_CTRL, 32'h8000_0002);
        @(negedge clk);
        chk("w64_valid0", 64'(ax64.axis_tvalid), 64'd1);
        chk("w64_data0",  ax64.axis_tdata, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("w64_keep0",  64'(ax64.axis_tkeep), 64'hFF);
        chk("w64_last0",  64'(ax64.axis_tlast), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w64_data1",  ax64.axis_tdata, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("w64_last1",  64'(ax64.axis_tlast), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w64_valid2", 64'(ax64.axis_tvalid), 64'd0);
        chk("w64_keep2",  64'(ax64.axis_tkeep), 64'd0);
        chk("w64_pkt",    64'(pkt64), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axis_pattern_master.md
# axis_pattern_master

Parametrised AXI-Stream test-pattern source; successor to the single-mode counter sample master. It emits packets of programmable length with selectable payload (counter, 32-bit LFSR, constant), optional continuous repetition with programmable inter-packet gap, and exposes packet/beat status. It sits behind the register bridge's ready/valid write port and drives a DMA or other AXIS sink on the same clock.

## Interface
- DATA_WIDTH, 32: tdata width; multiple of 32.
- LEN_WIDTH, 26: width of words-minus-one field; max packet 2^LEN_WIDTH beats.
- GAP_WIDTH, 8: width of inter-packet idle-cycle count.
- axis_aclk  in  1  sole clock.
- axis_reset  in  1  synchronous, active-high reset.
- cfg_waddr  in  2  register select: 0 CTRL, 1 LEN, 2 GAP, 3 SEED.
- cfg_wdata  in  32  write data.
- cfg_wvalid  in  1  write strobe.
- cfg_wready  out  1  tied 1.
- status_busy  out  1  state is SEND or GAP.
- status_pktCount  out  32  completed packets since enable, wraps.
- status_beatCount  out  LEN_WIDTH+1  beat index in current packet.
- axis_tdata  out  DATA_WIDTH  payload.
- axis_tkeep  out  DATA_WIDTH/8  all ones while tvalid, else 0.
- axis_tlast  out  1  final beat of packet.
- axis_tvalid  out  1  beat valid.
- axis_tready  in  1  sink ready.

## Operation
- Registers (write-only, reset 0): CTRL[31]=ena, CTRL[30]=continuous, CTRL[1:0]=mode (0 counter, 1 LFSR, 2 constant, 3 reserved → treated as counter); LEN[LEN_WIDTH-1:0]=nWordsMinusOne; GAP[GAP_WIDTH-1:0]=idle cycles; SEED[31:0].
- LEN, GAP, mode, continuous shadowed at packet start; writes mid-packet affect next packet only.
- States: IDLE, SEND, GAP, DONE.
- IDLE: ena=1 → SEND; load pattern from SEED (LFSR: seed 0 replaced by 1), beatCount=0, pktCount=0.
- SEND: tvalid=1. Each accepted beat (tvalid&tready): beatCount+1, pattern advances. Accepted beat with beatCount==nWordsMinusOne is tlast → pktCount+1; then continuous&ena → GAP (or SEND directly if GAP==0, no bubble, beatCount=0); else DONE.
- GAP: tvalid=0; counts GAP cycles, then SEND, beatCount=0.
- DONE: tvalid=0; ena=0 → IDLE.
- Clearing ena mid-packet never drops tvalid before tlast is accepted; packet completes, then DONE→IDLE. Clearing ena in GAP → IDLE next cycle.
- Pattern continues across packets (not reset per packet) so sinks detect drops.
- Counter: value+1 per beat, wraps mod 2^32; tdata = value replicated DATA_WIDTH/32 times.
- LFSR: Galois right shift, next = {1'b0,v[31:1]} ^ (v[0] ? 32'h80200003 : 0); tdata replicated.
- Constant: tdata = SEED replicated; never advances.
- axis_reset overrides everything: registers 0, IDLE, counters 0, all AXIS outputs 0, even mid-packet.

## Timing
- Reset values: tvalid, tlast, tkeep, tdata, status_* all 0; cfg_wready 1.
- CTRL write with ena=1 accepted at cycle n → tvalid=1 at n+1 with first pattern word.
- tdata/tlast stable while tvalid&!tready; advance only on handshake.
- tlast accepted at cycle m, GAP=G>0 → tvalid=0 for cycles m+1..m+G, 1 at m+G+1.
- Outputs are direct decodes of registered state/pattern; no combinational path from tready to tvalid.
- status_pktCount updates the cycle after tlast handshake.

## Structure
- Package axis_pattern_master_pkg: register address constants, CTRL bit positions, mode enum, state enum, LFSR polynomial 32'h80200003.
- Sub-module axis_pattern_gen: holds 32-bit pattern register, load/advance inputs, mode; replication done in top.

## Test plan
- LEN=3, mode counter, SEED=10, tready=1 → tdata 10,11,12,13, tlast on 13, then tvalid=0 (DONE), pktCount=1.
- Mode LFSR, SEED=1, LEN=1 → tdata 0x00000001, 0x80200003; SEED=0 gives same sequence.
- Continuous, LEN=1, GAP=2 → beats 2, 2 idle cycles, repeat; GAP=0 → back-to-back, tlast every 2nd beat.
- tready toggled randomly → tdata/tlast held during stalls; sequence identical to tready=1 run.
- ena cleared at beat 1 of LEN=7 packet → remaining beats through tlast delivered, then IDLE; axis_reset asserted mid-packet → all outputs 0 next cycle.
- DATA_WIDTH=64, constant mode, SEED=0xDEADBEEF → tdata 0xDEADBEEFDEADBEEF, tkeep 8'hFF.
